multi_clock_divider: RTL and testbench

Parametrised multi-channel clock-enable generator. Produces NUM_CH independent divided square waves and single-cycle tick strobes from the 100 MHz master clock, each with a runtime-programmable divisor. Also produces the fixed 25 MHz pixel enable. Sits beside the VGA, seven-segment and board-logic blocks, which consume its ticks as clock enables.

---
 rtl/multi_clock_divider.sv | 101 ++++++++++
 tb/tb_multi_clock_divider.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// Multi-channel clock-enable generator: per-channel programmable tick/square-wave
// dividers with shadowed divisors, plus a fixed divide-by-four pixel enable.
module multi_clock_divider #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned DIV_INIT = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic              pix_en
);

  localparam logic [CNT_W-1:0] DivInit = CNT_W'(DIV_INIT);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic [CNT_W-1:0] deff;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             wr, term, restart;

    assign wr = cfg_we && (cfg_ch == 4'(i));

    always_comb begin
      deff    = (act_q == '0) ? CNT_W'(1) : act_q;
      term    = (cnt_q == deff - CNT_W'(1));
      restart = sync || !ch_en[i];
      cnt_d   = cnt_q;
      act_d   = act_q;
      shd_d   = shd_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      pend_d  = pend_q;
      if (restart || term) begin
        // Period boundary: the only point where a new divisor may take effect.
        cnt_d  = '0;
        clk_d  = restart ? 1'b0 : ~clk_q;
        tick_d = !restart;
        act_d  = wr ? cfg_div : (pend_q ? shd_q : act_q);
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wr) begin
          pend_d = 1'b1;
        end
      end
      if (wr) begin
        shd_d = cfg_div;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        act_q  <= DivInit;
        shd_q  <= DivInit;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
        pend_q <= pend_d;
      end
    end

    assign tick[i]        = tick_q;
    assign clk_out[i]     = clk_q;
    assign cfg_pending[i] = pend_q;
  end

  logic [1:0] pix_q;
  logic       pix_en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_q    <= 2'b00;
      pix_en_q <= 1'b0;
    end else begin
      pix_q    <= pix_q + 2'b01;
      pix_en_q <= (pix_q == 2'b11);
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Randomized bench for multi_clock_divider; a timestamp-based reference model
// predicts every tick, clk_out, cfg_pending and pix_en value.
module tb_multi_clock_divider;

  localparam int unsigned NumCh   = 4;
  localparam int unsigned CntW    = 8;
  localparam int unsigned DivInit = 4;
  localparam int unsigned Cycles  = 4000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [3:0]       cfg_ch;
  logic [CntW-1:0]  cfg_div;
  logic [NumCh-1:0] ch_en;
  logic             sync;
  logic [NumCh-1:0] tick;
  logic [NumCh-1:0] clk_out;
  logic [NumCh-1:0] cfg_pending;
  logic             pix_en;

  multi_clock_divider #(
    .NUM_CH  (NumCh),
    .CNT_W   (CntW),
    .DIV_INIT(DivInit)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .ch_en      (ch_en),
    .sync       (sync),
    .tick       (tick),
    .clk_out    (clk_out),
    .cfg_pending(cfg_pending),
    .pix_en     (pix_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: each channel remembers the absolute edge number of its next terminal count.
  longint edge_n = 0;
  longint period_end [NumCh];
  int     m_act [NumCh];
  int     m_shd [NumCh];
  bit     m_pend [NumCh];
  bit     m_lvl [NumCh];
  bit     m_tick [NumCh];
  int     pix_k = 0;

  function automatic int deff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_step();
    edge_n++;
    if (!rst_n) begin
      pix_k = 0;
      for (int c = 0; c < NumCh; c++) begin
        m_act[c]      = DivInit;
        m_shd[c]      = DivInit;
        m_pend[c]     = 1'b0;
        m_lvl[c]      = 1'b0;
        m_tick[c]     = 1'b0;
        period_end[c] = edge_n + deff(DivInit);
      end
    end else begin
      pix_k++;
      for (int c = 0; c < NumCh; c++) begin
        bit wr, stop;
        wr   = cfg_we && (int'(cfg_ch) == c);
        stop = sync || !ch_en[c];
        if (stop || edge_n == period_end[c]) begin
          if (wr) m_act[c] = int'(cfg_div);
          else if (m_pend[c]) m_act[c] = m_shd[c];
          m_pend[c]     = 1'b0;
          m_tick[c]     = !stop;
          m_lvl[c]      = stop ? 1'b0 : !m_lvl[c];
          period_end[c] = edge_n + deff(m_act[c]);
        end else begin
          m_tick[c] = 1'b0;
          if (wr) m_pend[c] = 1'b1;
        end
        if (wr) m_shd[c] = int'(cfg_div);
      end
    end
  endtask

  task automatic compare();
    logic [NumCh-1:0] et, ec, ep;
    for (int c = 0; c < NumCh; c++) begin
      et[c] = m_tick[c];
      ec[c] = m_lvl[c];
      ep[c] = m_pend[c];
    end
    check("tick", 32'(tick), 32'(et));
    check("clk_out", 32'(clk_out), 32'(ec));
    check("cfg_pending", 32'(cfg_pending), 32'(ep));
    check("pix_en", 32'(pix_en), 32'((pix_k > 0) && (pix_k % 4 == 0)));
  endtask

  task automatic drive(input int cyc);
    rst_n  = 1'b1;
    cfg_we = 1'b0;
    sync   = 1'b0;
    if (cyc < 2) begin
      rst_n = 1'b0;
    end else if (cyc < 100) begin
      ch_en = 4'b0001;
    end else if (cyc == 2000) begin
      ch_en   = '1;
      cfg_we  = 1'b1;
      cfg_ch  = 4'd1;
      cfg_div = 8'd9;
    end else if (cyc == 2001) begin
      rst_n = 1'b0;
    end else if (cyc > 3000 && cyc < 3400) begin
      // Equal and unequal divisors under frequent sync pulses.
      ch_en   = '1;
      cfg_we  = ($urandom_range(0, 15) == 0);
      cfg_ch  = 4'($urandom_range(0, 3));
      cfg_div = ($urandom_range(0, 1) == 0) ? 8'd5 : 8'd7;
      sync    = ($urandom_range(0, 19) == 0);
    end else begin
      for (int c = 0; c < NumCh; c++) begin
        if ($urandom_range(0, 63) == 0) ch_en[c] = !ch_en[c];
      end
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_ch  = 4'($urandom_range(0, 7));
      cfg_div = 8'($urandom_range(0, 12));
      sync    = ($urandom_range(0, 99) == 0);
      rst_n   = ($urandom_range(0, 499) != 0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    ch_en   = '0;
    sync    = 1'b0;
    for (int cyc = 0; cyc < Cycles; cyc++) begin
      @(posedge clk);
      #1;
      model_step();
      compare();
      drive(cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
